// File: rtl/captura_defs.sv
// -----------------------------------------------------------------------------
// captura_defs
//   Shared definitions for the OV7670 frame-capture controller:
//     - capture FSM state encoding
//     - RGB565 byte field positions used to build an RGB332 pixel
//     - colour-bar palette for the optional test pattern
//   Optional feature macro: CAPTURA_TEST_PATTERN_EN (consumed by captura_ctrl).
// -----------------------------------------------------------------------------
package captura_defs;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    WAIT_VS     = 3'd1,
    WAIT_VS_END = 3'd2,
    CAPTURE     = 3'd3,
    DONE        = 3'd4
  } capt_state_t;

  // RGB565 arrives as two bytes: RRRRRGGG then GGGBBBBB.
  // RGB332 = {R[4:2], G[5:3], B[4:3]}, i.e. the top bits of each channel.
  localparam int B1_R_HI = 7;
  localparam int B1_R_LO = 5;
  localparam int B1_G_HI = 2;
  localparam int B1_G_LO = 0;
  localparam int B2_B_HI = 4;
  localparam int B2_B_LO = 3;

  // Eight vertical colour bars, left to right.
  localparam logic [7:0] PAL_BAR0 = 8'hFF;
  localparam logic [7:0] PAL_BAR1 = 8'hFC;
  localparam logic [7:0] PAL_BAR2 = 8'h1F;
  localparam logic [7:0] PAL_BAR3 = 8'h1C;
  localparam logic [7:0] PAL_BAR4 = 8'hE3;
  localparam logic [7:0] PAL_BAR5 = 8'hE0;
  localparam logic [7:0] PAL_BAR6 = 8'h03;
  localparam logic [7:0] PAL_BAR7 = 8'h00;

  function automatic logic [7:0] bar_color(input logic [2:0] idx);
    case (idx)
      3'd0:    return PAL_BAR0;
      3'd1:    return PAL_BAR1;
      3'd2:    return PAL_BAR2;
      3'd3:    return PAL_BAR3;
      3'd4:    return PAL_BAR4;
      3'd5:    return PAL_BAR5;
      3'd6:    return PAL_BAR6;
      default: return PAL_BAR7;
    endcase
  endfunction

endpackage

// File: rtl/captura_edge.sv
// -----------------------------------------------------------------------------
// captura_edge
//   Registers one camera framing signal into the PCLK domain and derives
//   single-cycle rise/fall pulses from the registered copy.
//   Ports:
//     clk     - camera PCLK
//     rst_n   - asynchronous active-low reset
//     i_sig   - raw framing input (VSYNC or HREF)
//     o_level - registered level
//     o_rise  - high for one cycle when o_level goes 0->1
//     o_fall  - high for one cycle when o_level goes 1->0
// -----------------------------------------------------------------------------
module captura_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic i_sig,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic r_q;
  logic r_q_d;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q   <= 1'b0;
      r_q_d <= 1'b0;
    end else begin
      r_q   <= i_sig;
      r_q_d <= r_q;
    end
  end

  assign o_level = r_q;
  assign o_rise  = r_q & ~r_q_d;
  assign o_fall  = ~r_q & r_q_d;

endmodule

// File: rtl/captura_ctrl.sv
// -----------------------------------------------------------------------------
// captura_ctrl
//   OV7670 frame-capture controller, clocked by the camera PCLK. Grabs one
//   frame (or frames back to back in continuous mode) framed by VSYNC/HREF,
//   packs RGB565 byte pairs into RGB332 pixels and writes them to a linear
//   framebuffer (addr = row*H_RES + col).
//
//   Parameters: H_RES (pixels kept per line), V_RES (lines kept per frame),
//               ADDR_W (framebuffer address width, 2^ADDR_W >= H_RES*V_RES).
//   Ports:
//     clk, async_reset      - PCLK, asynchronous active-low reset
//     vsync, href, px_data  - camera framing and data bus
//     start                 - one-cycle capture request (ignored while busy)
//     cont                  - continuous mode, sampled at end of frame
//     mem_addr/data/we      - registered framebuffer write port
//     busy                  - controller not idle
//     frame_done            - one-cycle end-of-frame pulse
//     frame_err             - frame ended short; held until next start
//
//   Optional feature: define CAPTURA_TEST_PATTERN_EN to replace pixel data
//   with eight vertical colour bars (framing/addressing unchanged).
// -----------------------------------------------------------------------------
module captura_ctrl
  import captura_defs::*;
#(
  parameter int H_RES  = 160,
  parameter int V_RES  = 120,
  parameter int ADDR_W = 15
) (
  input  logic              clk,
  input  logic              async_reset,
  input  logic              vsync,
  input  logic              href,
  input  logic [7:0]        px_data,
  input  logic              start,
  input  logic              cont,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_data,
  output logic              mem_we,
  output logic              busy,
  output logic              frame_done,
  output logic              frame_err
);

  localparam int COL_W = $clog2(H_RES + 1);
  localparam int ROW_W = $clog2(V_RES + 1);

  localparam logic [COL_W-1:0]  COL_END   = COL_W'(H_RES);
  localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(H_RES - 1);
  localparam logic [ROW_W-1:0]  ROW_END   = ROW_W'(V_RES);
  localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(V_RES - 1);
  localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(H_RES);

  // ---------------------------------------------------------------------------
  // Framing edge detection
  // ---------------------------------------------------------------------------
  logic w_vs_lvl, w_vs_rise, w_vs_fall;
  logic w_href_lvl, w_href_rise, w_href_fall;

  captura_edge u_vs_edge (
    .clk     (clk),
    .rst_n   (async_reset),
    .i_sig   (vsync),
    .o_level (w_vs_lvl),
    .o_rise  (w_vs_rise),
    .o_fall  (w_vs_fall)
  );

  captura_edge u_href_edge (
    .clk     (clk),
    .rst_n   (async_reset),
    .i_sig   (href),
    .o_level (w_href_lvl),
    .o_rise  (w_href_rise),
    .o_fall  (w_href_fall)
  );

  // The data bus goes through the same single register stage as HREF so a
  // byte is always consumed together with the HREF level that framed it.
  logic [7:0] r_px;

  always_ff @(posedge clk or negedge async_reset) begin
    if (!async_reset) r_px <= '0;
    else              r_px <= px_data;
  end

  // ---------------------------------------------------------------------------
  // Capture state
  // ---------------------------------------------------------------------------
  capt_state_t       r_state;
  logic [COL_W-1:0]  r_col;
  logic [ROW_W-1:0]  r_row;
  logic              r_phase;
  logic [5:0]        r_b1_bits;    // R[4:2] and G[5:3] from the first byte
  logic [ADDR_W-1:0] r_addr;       // address of the next stored pixel
  logic [ADDR_W-1:0] r_line_base;  // row*H_RES kept as a running sum

  logic [ADDR_W-1:0] r_mem_addr;
  logic [7:0]        r_mem_data;
  logic              r_mem_we;
  logic              r_busy;
  logic              r_frame_done;
  logic              r_frame_err;

  // A fresh HREF rise always starts on byte 0, even if a fall was missed.
  logic w_byte0;
  logic w_in_frame;
  logic w_px_strobe;
  logic w_last;
  logic [7:0] w_pixel;

  assign w_byte0     = !r_phase || w_href_rise;
  assign w_in_frame  = (r_col < COL_END) && (r_row < ROW_END);
  assign w_px_strobe = (r_state == CAPTURE) && w_href_lvl && !w_byte0;
  assign w_last      = w_px_strobe && w_in_frame &&
                       (r_col == COL_LAST) && (r_row == ROW_LAST);

`ifdef CAPTURA_TEST_PATTERN_EN
  // Bar index = col*8/H_RES; the divisor is a constant.
  logic [COL_W+2:0] w_col_x8;
  logic [2:0]       w_bar;

  assign w_col_x8 = {r_col, 3'b000};
  assign w_bar    = 3'(w_col_x8 / (COL_W + 3)'(H_RES));
  assign w_pixel  = bar_color(w_bar);
`else
  assign w_pixel  = {r_b1_bits, r_px[B2_B_HI:B2_B_LO]};
`endif

  always_ff @(posedge clk or negedge async_reset) begin
    if (!async_reset) begin
      r_state      <= IDLE;
      r_col        <= '0;
      r_row        <= '0;
      r_phase      <= 1'b0;
      r_b1_bits    <= '0;
      r_addr       <= '0;
      r_line_base  <= '0;
      r_mem_addr   <= '0;
      r_mem_data   <= '0;
      r_mem_we     <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_mem_we     <= 1'b0;
      r_frame_done <= 1'b0;

      case (r_state)
        IDLE: begin
          if (start) begin
            r_state     <= WAIT_VS;
            r_busy      <= 1'b1;
            r_frame_err <= 1'b0;
          end
        end

        // Only a VSYNC rise seen here guarantees we start on a frame boundary.
        WAIT_VS: begin
          if (w_vs_rise) r_state <= WAIT_VS_END;
        end

        WAIT_VS_END: begin
          if (w_vs_fall) begin
            r_state     <= CAPTURE;
            r_col       <= '0;
            r_row       <= '0;
            r_phase     <= 1'b0;
            r_addr      <= '0;
            r_line_base <= '0;
          end
        end

        CAPTURE: begin
          if (w_href_fall) begin
            // End of line: an odd trailing byte is dropped with the phase.
            r_col   <= '0;
            r_phase <= 1'b0;
            if (r_row != ROW_END) begin
              r_row       <= r_row + ROW_W'(1);
              r_line_base <= r_line_base + LINE_STEP;
              r_addr      <= r_line_base + LINE_STEP;
            end
          end else if (w_href_lvl) begin
            if (w_byte0) begin
              r_b1_bits <= {r_px[B1_R_HI:B1_R_LO], r_px[B1_G_HI:B1_G_LO]};
              r_phase   <= 1'b1;
            end else begin
              r_phase <= 1'b0;
              if (r_col != COL_END) r_col <= r_col + COL_W'(1);
              if (w_in_frame) begin
                r_mem_we   <= 1'b1;
                r_mem_addr <= r_addr;
                r_mem_data <= w_pixel;
                r_addr     <= r_addr + ADDR_W'(1);
              end
            end
          end

          if (w_last) begin
            r_state      <= DONE;
            r_frame_done <= 1'b1;
          end else if (w_vs_rise) begin
            r_state      <= DONE;
            r_frame_done <= 1'b1;
            r_frame_err  <= 1'b1;
          end
        end

        // A short frame ends on VSYNC rising, so VSYNC may still be high here;
        // then the next frame's start edge has already happened.
        DONE: begin
          if (cont) begin
            r_state <= w_vs_lvl ? WAIT_VS_END : WAIT_VS;
          end else begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end

        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign mem_addr   = r_mem_addr;
  assign mem_data   = r_mem_data;
  assign mem_we     = r_mem_we;
  assign busy       = r_busy;
  assign frame_done = r_frame_done;
  assign frame_err  = r_frame_err;

endmodule

// File: tb/tb_captura_ctrl.sv
// -----------------------------------------------------------------------------
// tb_captura_ctrl
//   Scoreboard bench for captura_ctrl. The stimulus thread pushes the expected
//   framebuffer writes and end-of-frame events into queues as it drives camera
//   bytes; a monitor on the falling clock edge pops and compares every write
//   and every frame_done pulse. Directed scenarios: full frame, overlong/odd
//   lines with a short frame, continuous mode, and reset in mid-frame.
//   Honours CAPTURA_TEST_PATTERN_EN for the expected pixel values.
// -----------------------------------------------------------------------------
module tb_captura_ctrl;

  localparam int H  = 160;
  localparam int V  = 120;
  localparam int AW = 15;

  logic          clk = 1'b0;
  logic          async_reset = 1'b1;
  logic          vsync = 1'b0;
  logic          href = 1'b0;
  logic [7:0]    px_data = 8'h00;
  logic          start = 1'b0;
  logic          cont = 1'b0;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_data;
  logic          mem_we;
  logic          busy;
  logic          frame_done;
  logic          frame_err;

  always #5 clk = ~clk;

  captura_ctrl #(.H_RES(H), .V_RES(V), .ADDR_W(AW)) dut (
    .clk         (clk),
    .async_reset (async_reset),
    .vsync       (vsync),
    .href        (href),
    .px_data     (px_data),
    .start       (start),
    .cont        (cont),
    .mem_addr    (mem_addr),
    .mem_data    (mem_data),
    .mem_we      (mem_we),
    .busy        (busy),
    .frame_done  (frame_done),
    .frame_err   (frame_err)
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [7:0]    data;
  } wr_t;

  typedef struct packed {
    logic err;
    logic with_wr;
  } done_t;

  wr_t   wr_q[$];
  done_t done_q[$];

  int checks = 0;
  int errors = 0;
  int wr_seen = 0;
  int done_seen = 0;
  int tb_row = 0;
  logic [AW-1:0] last_addr = '0;
  logic [7:0]    last_data = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference pixel: RGB332 from the top bits of R, G, B, or the colour bar.
  function automatic logic [7:0] exp_px(input logic [7:0] b1, input logic [7:0] b2, input int col);
`ifdef CAPTURA_TEST_PATTERN_EN
    case (col * 8 / H)
      0:       return 8'hFF;
      1:       return 8'hFC;
      2:       return 8'h1F;
      3:       return 8'h1C;
      4:       return 8'hE3;
      5:       return 8'hE0;
      6:       return 8'h03;
      default: return 8'h00;
    endcase
`else
    return {b1[7:5], b1[2:0], b2[4:3]};
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // VSYNC pulse; when it cuts a frame short, a frame_done with error is due.
  task automatic vs_pulse(input bit expect_cut);
    if (expect_cut) done_q.push_back('{err: 1'b1, with_wr: 1'b0});
    vsync = 1'b1;
    repeat (3) tick();
    vsync = 1'b0;
    tb_row = 0;
    repeat (4) tick();
  endtask

  // One HREF line of nbytes; b1/b2 vary per pixel when vary is set.
  task automatic send_line(input int nbytes, input logic [7:0] s1, input logic [7:0] s2,
                           input bit vary, input bit expect_wr);
    logic [7:0] b1;
    logic [7:0] b2;
    int k;
    b1 = s1;
    for (int i = 0; i < nbytes; i++) begin
      k = i / 2;
      href = 1'b1;
      if (i % 2 == 0) begin
        b1 = vary ? (s1 ^ 8'(k * 5)) : s1;
        px_data = b1;
      end else begin
        b2 = vary ? (s2 + 8'(k)) : s2;
        px_data = b2;
        if (expect_wr && k < H && tb_row < V) begin
          wr_q.push_back('{addr: AW'(tb_row * H + k), data: exp_px(b1, b2, k)});
          if (k == H - 1 && tb_row == V - 1) done_q.push_back('{err: 1'b0, with_wr: 1'b1});
        end
      end
      tick();
    end
    href = 1'b0;
    px_data = 8'h00;
    tb_row++;
    repeat (4) tick();
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((wr_q.size() != 0 || done_q.size() != 0) && n < 400) begin
      tick();
      n++;
    end
    check({tag, "_wr_left"}, 32'(wr_q.size()), 32'd0);
    check({tag, "_done_left"}, 32'(done_q.size()), 32'd0);
  endtask

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    wr_t   we_exp;
    done_t de_exp;
    if (async_reset) begin
      if (mem_we) begin
        wr_seen++;
        last_addr = mem_addr;
        last_data = mem_data;
        if (wr_q.size() == 0) begin
          check("unexpected_we", 32'(mem_addr), 32'hFFFF_FFFF);
        end else begin
          we_exp = wr_q.pop_front();
          check("wr_addr", 32'(mem_addr), 32'(we_exp.addr));
          check("wr_data", 32'(mem_data), 32'(we_exp.data));
        end
      end
      if (frame_done) begin
        done_seen++;
        if (done_q.size() == 0) begin
          check("unexpected_done", 32'(frame_err), 32'hFFFF_FFFF);
        end else begin
          de_exp = done_q.pop_front();
          check("done_err", 32'(frame_err), 32'(de_exp.err));
          check("done_with_wr", 32'(mem_we), 32'(de_exp.with_wr));
        end
      end
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    #2 async_reset = 1'b0;
    repeat (3) tick();
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_data", 32'(mem_data), 32'd0);
    check("rst_ctrl", {26'd0, mem_we, busy, frame_done, frame_err, 2'b00}, 32'd0);
    async_reset = 1'b1;
    tick();

    // Full frame, constant F8/1F pixels.
    cont = 1'b0;
    pulse_start();
    tick();
    check("busy_after_start", 32'(busy), 32'd1);
    vs_pulse(1'b0);
    wr_seen = 0;
    for (int r = 0; r < V; r++) send_line(2 * H, 8'hF8, 8'h1F, 1'b0, 1'b1);
    drain("full");
    check("full_count", 32'(wr_seen), 32'd19200);
    check("full_last_addr", 32'(last_addr), 32'd19199);
`ifdef CAPTURA_TEST_PATTERN_EN
    check("full_last_data", 32'(last_data), 32'h00);
`else
    check("full_last_data", 32'(last_data), 32'hE3);
`endif
    check("full_err", 32'(frame_err), 32'd0);
    check("full_idle", 32'(busy), 32'd0);

    // Short frame: overlong and odd lines, cut by VSYNC after 50 lines.
    pulse_start();
    vs_pulse(1'b0);
    wr_seen = 0;
    send_line(330, 8'h3C, 8'hA5, 1'b1, 1'b1);
    send_line(321, 8'hC3, 8'h5A, 1'b1, 1'b1);
    for (int r = 2; r < 50; r++) send_line(2 * H, 8'(r * 17), 8'(r * 29), 1'b1, 1'b1);
    vs_pulse(1'b1);
    drain("short");
    check("short_count", 32'(wr_seen), 32'd8000);
    check("short_last_addr", 32'(last_addr), 32'd7999);
    check("short_err", 32'(frame_err), 32'd1);
    check("short_idle", 32'(busy), 32'd0);

    // Continuous mode, three short frames back to back.
    cont = 1'b1;
    done_seen = 0;
    pulse_start();
    tick();
    check("start_clears_err", 32'(frame_err), 32'd0);
    vs_pulse(1'b0);
    send_line(2 * H, 8'h12, 8'h34, 1'b1, 1'b1);
    send_line(2 * H, 8'h56, 8'h78, 1'b1, 1'b1);
    vs_pulse(1'b1);
    send_line(2 * H, 8'h9A, 8'hBC, 1'b1, 1'b1);
    pulse_start();
    send_line(2 * H, 8'hDE, 8'hF0, 1'b1, 1'b1);
    vs_pulse(1'b1);
    check("busy_start_ignored", 32'(frame_err), 32'd1);
    check("cont_busy", 32'(busy), 32'd1);
    send_line(2 * H, 8'h0F, 8'hE1, 1'b1, 1'b1);
    cont = 1'b0;
    send_line(2 * H, 8'h77, 8'h88, 1'b1, 1'b1);
    vs_pulse(1'b1);
    drain("cont");
    check("cont_done_count", 32'(done_seen), 32'd3);
    check("cont_idle", 32'(busy), 32'd0);

    // Reset after pixel 500 of a frame.
    pulse_start();
    vs_pulse(1'b0);
    wr_seen = 0;
    for (int r = 0; r < 3; r++) send_line(2 * H, 8'h4B, 8'hD2, 1'b1, 1'b1);
    send_line(40, 8'h66, 8'h99, 1'b1, 1'b1);
    drain("pre_rst");
    check("pre_rst_count", 32'(wr_seen), 32'd500);
    href = 1'b1;
    px_data = 8'hAA;
    tick();
    async_reset = 1'b0;
    repeat (8) tick();
    href = 1'b0;
    repeat (2) tick();
    check("in_rst_addr", 32'(mem_addr), 32'd0);
    check("in_rst_data", 32'(mem_data), 32'd0);
    check("in_rst_ctrl", {26'd0, mem_we, busy, frame_done, frame_err, 2'b00}, 32'd0);
    async_reset = 1'b1;
    tick();
    vs_pulse(1'b0);
    send_line(2 * H, 8'h11, 8'h22, 1'b1, 1'b0);
    drain("post_rst_idle");
    check("post_rst_no_we", 32'(wr_seen), 32'd500);
    pulse_start();
    vs_pulse(1'b0);
    send_line(2 * H, 8'hF8, 8'h1F, 1'b0, 1'b1);
    send_line(2 * H, 8'h81, 8'h7E, 1'b1, 1'b1);
    vs_pulse(1'b1);
    drain("recap");
    check("recap_count", 32'(wr_seen), 32'd820);
    check("recap_last_addr", 32'(last_addr), 32'd319);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
